tp_load_ctrl: RTL and testbench
===============================

# tp_load_ctrl

Sequencer that loads a program or data frame into the tiny processor core and then releases it to run. It sits between a byte-stream requester (FPGA demo glue or a host bridge) and the processor's serial load port (`sclk_out`, `mosi_out`, `mode_out`, `done_in`). It generates the processor clock `sclk_out` from the system clock and serializes bytes MSB-first. It watches `done_in` to confirm load completion and flags a timeout if the core never acknowledges.

## Interface
- `CLK_DIV`, 4: clk cycles per `sclk_out` half-period; must be ≥1.
- `WORDS`, 16: bytes per load frame; must be ≥1.
- `TIMEOUT`, 255: maximum `sclk_out` periods spent waiting for `done_in`.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a frame; sampled only in IDLE.
- `mode_in` in 2: frame mode, latched on accepted `start`.
- `byte_valid` in 1: requester has a byte.
- `byte_data` in 8: byte payload.
- `byte_ready` out 1: byte accepted when `byte_valid && byte_ready`.
- `sclk_out` out 1: processor clock / serial clock.
- `mosi_out` out 1: serial data, MSB first.
- `mode_out` out 2: processor mode bits.
- `done_in` in 1: processor load-complete flag, generated in the `sclk_out` domain.
- `busy` out 1: high outside IDLE.
- `frame_done` out 1: one-clk pulse when `done_in` is seen.
- `err` out 1: sticky timeout / bad-mode flag; cleared by the next accepted `start`.

## Operation
- Modes: 00 RUN, 01 LOAD_PROG, 10 LOAD_DATA, 11 reserved.
- States: IDLE, LOAD, WAIT_DONE.
- IDLE
  - `mode_out`=00 and `sclk_out` free-runs, so the core executes.
  - `start` with `mode_in`∈{01,10} → LOAD, with `mode_out` set to the latched mode.
  - `start` with `mode_in`=00: no-op.
  - `start` with `mode_in`=11: sets `err`, stays in IDLE.
- LOAD
  - `byte_ready`=1 while the shift register is empty.
  - After a handshake, the byte is shifted out over 8 `sclk_out` periods. `mosi_out` changes only on the clk cycle in which `sclk_out` falls (or enters low from a stall), so the core samples on the rising edge.
  - With no byte pending, `sclk_out` is held low and `mosi_out`=0 (stall); no edges are generated.
  - The next byte may be accepted during the final bit period, giving back-to-back bytes with no stall.
  - After `WORDS` bytes → WAIT_DONE. `byte_ready`=0 from the last handshake onward.
- WAIT_DONE
  - `sclk_out` free-runs with `mosi_out`=0.
  - `done_in` passes through a 2-flop synchronizer. Synchronized high → `frame_done` pulse, `mode_out`=00, → IDLE.
  - `TIMEOUT` full `sclk_out` periods without `done_in` → `err`=1, `mode_out`=00, → IDLE.
- `start` while `busy` is ignored. `byte_valid` outside LOAD is ignored and never lost: the requester holds it.
- Byte counter: `$clog2(WORDS+1)` bits, reset to 0 on entering LOAD, no wrap.
- Timeout counter: `$clog2(TIMEOUT+1)` bits, saturating, counts `sclk_out` rising edges.
- Reset values: `sclk_out`=0, `mosi_out`=0, `mode_out`=00, `byte_ready`=0, `busy`=0, `frame_done`=0, `err`=0; state IDLE; all counters 0.
- Reset mid-frame aborts on the next clk edge with the reset values above; no partial byte is completed.

## Timing
- Accepted `start` → `busy`, `mode_out` valid, and `byte_ready` all asserted on the next clk edge.
- Handshake → first bit on `mosi_out` at most 1 clk later, with `sclk_out` low. The first rising edge follows `CLK_DIV` clks later.
- One byte = 2·8·`CLK_DIV` clk cycles; one unstalled frame = 16·`CLK_DIV`·`WORDS` clk cycles.
- `done_in` is seen 2 clks after it goes high (synchronizer). `frame_done` and `mode_out`=00 take effect on the same edge.
- `sclk_out` free-running duty cycle is exactly 50%. When a stall ends, the first rising edge comes `CLK_DIV` clks after `mosi_out` is updated.

## Structure
- Package `tp_ctrl_pkg`:
  - `tp_mode_e` (MODE_RUN, MODE_LOAD_PROG, MODE_LOAD_DATA, MODE_RSVD)
  - `tp_ld_state_e`
  - bits-per-byte constant 8
- Sub-module `sclk_gen`:
  - Inputs: `en`, `hold_low`.
  - Outputs: `sclk_out` plus one-clk `rise` and `fall` strobes.
  - Parameterized by `CLK_DIV`.
- Top: FSM, shift register, byte counter, timeout counter, `done_in` synchronizer.

## Test plan
- Reset, then 20 idle clks → `sclk_out` toggles every 4 clks; `mode_out`=00; `busy`=0; `err`=0.
- `start`, `mode_in`=01, WORDS=2, bytes 0xA5,0x3C back-to-back → `mosi_out` sequence 1010010100111100 sampled on `sclk_out` rises. `byte_ready` drops after the second handshake. `mode_out`=01 throughout.
- Same frame with `byte_valid` low for 40 clks between bytes → `sclk_out` held low and zero extra rising edges during the gap; byte content unchanged.
- After the frame, `done_in` goes high on the 5th WAIT_DONE `sclk_out` period → `frame_done` single pulse 2 clks later; `mode_out`=00; `busy`=0.
- `done_in` never asserts, TIMEOUT=255 → `err`=1 after 255 periods, then IDLE. Next valid `start` clears `err`.
- `start` with `mode_in`=11 → `err`=1, `busy` stays 0. `rst_n` low mid-byte → next edge has `sclk_out`=0, `mode_out`=00, `busy`=0.

Source files
------------

// File: rtl/tp_ctrl_pkg.sv
// Shared types and constants for the tiny-processor load controller.
package tp_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'b00,
        MODE_LOAD_PROG = 2'b01,
        MODE_LOAD_DATA = 2'b10,
        MODE_RSVD      = 2'b11
    } tp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_LOAD      = 2'b01,
        ST_WAIT_DONE = 2'b10
    } tp_ld_state_e;

    localparam int unsigned BITS_PER_BYTE = 8;

    function automatic logic mode_is_load(input logic [1:0] m);
        return (m == MODE_LOAD_PROG) || (m == MODE_LOAD_DATA);
    endfunction

endpackage

// File: rtl/sclk_gen.sv
// Divided serial/processor clock with strobes flagging the edge about to happen.
module sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic hold_low,
    output logic sclk_out,
    output logic rise,
    output logic fall
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          toggle;

    // Strobes are combinational: they are high in the cycle whose closing edge moves sclk.
    always_comb begin
        toggle = en && !hold_low && (cnt_q == CNT_MAX);
        rise   = toggle && !sclk_q;
        fall   = toggle && sclk_q;
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en || hold_low) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (toggle) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_out = sclk_q;

endmodule

// File: rtl/tp_load_ctrl.sv
// Loads a program/data frame into the tiny processor over its serial port,
// then waits for the core's done flag (or times out) and releases it to run.
module tp_load_ctrl
    import tp_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned WORDS   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode_in,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       sclk_out,
    output logic       mosi_out,
    output logic [1:0] mode_out,
    input  logic       done_in,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);
    localparam int unsigned BCW = $clog2(WORDS + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] WORDS_L = BCW'(WORDS);
    localparam logic [TCW-1:0] TMAX    = TCW'(TIMEOUT);
    localparam logic [3:0]     BITS_L  = 4'(BITS_PER_BYTE);

    tp_ld_state_e   state_q, state_d;
    tp_mode_e       mode_q, mode_d;
    logic [7:0]     sh_q, sh_d;
    logic [3:0]     bits_q, bits_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           err_q, err_d;
    logic           fdone_q, fdone_d;
    logic           sync1_q, sync2_q;
    logic           hold_low, rise, fall;
    logic           byte_end, timeout_hit, handshake;

    sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (1'b1),
        .hold_low (hold_low),
        .sclk_out (sclk_out),
        .rise     (rise),
        .fall     (fall)
    );

    assign byte_end    = (state_q == ST_LOAD) && fall && (bits_q == 4'd1);
    assign timeout_hit = (state_q == ST_WAIT_DONE) && fall && (tcnt_q == TMAX);
    assign handshake   = byte_valid && byte_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start && mode_is_load(mode_in)) state_d = ST_LOAD;
            ST_LOAD:      if (byte_end && (bcnt_q == WORDS_L)) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (sync2_q || timeout_hit) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Next byte is taken either into an empty shifter or on the fall that ends the last bit.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        hold_low   = (state_q == ST_LOAD) && (bits_q == 4'd0);
        byte_ready = (state_q == ST_LOAD) && (bcnt_q < WORDS_L) &&
                     ((bits_q == 4'd0) || ((bits_q == 4'd1) && fall));
    end

    always_comb begin
        mode_d  = mode_q;
        sh_d    = sh_q;
        bits_d  = bits_q;
        bcnt_d  = bcnt_q;
        err_d   = err_q;
        fdone_d = 1'b0;
        tcnt_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start && mode_is_load(mode_in)) begin
                    mode_d = tp_mode_e'(mode_in);
                    err_d  = 1'b0;
                    bcnt_d = '0;
                end else if (start && (mode_in == MODE_RSVD)) begin
                    err_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    sh_d   = byte_data;
                    bits_d = BITS_L;
                    bcnt_d = bcnt_q + 1'b1;
                end else if (fall && (bits_q != 4'd0)) begin
                    // Shifting past the last bit leaves zero, which is the stall level of mosi.
                    sh_d   = {sh_q[6:0], 1'b0};
                    bits_d = bits_q - 4'd1;
                end
            end
            ST_WAIT_DONE: begin
                tcnt_d = (rise && (tcnt_q != TMAX)) ? tcnt_q + 1'b1 : tcnt_q;
                if (sync2_q) begin
                    fdone_d = 1'b1;
                    mode_d  = MODE_RUN;
                end else if (timeout_hit) begin
                    err_d  = 1'b1;
                    mode_d = MODE_RUN;
                end
            end
            default: mode_d = MODE_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= MODE_RUN;
            sh_q    <= '0;
            bits_q  <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            fdone_q <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            sh_q    <= sh_d;
            bits_q  <= bits_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            fdone_q <= fdone_d;
            sync1_q <= done_in;
            sync2_q <= sync1_q;
        end
    end

    assign mosi_out   = sh_q[7];
    assign mode_out   = mode_q;
    assign frame_done = fdone_q;
    assign err        = err_q;

endmodule

// File: tb/tb_tp_load_ctrl.sv
// Directed bench for tp_load_ctrl with WORDS=2, CLK_DIV=4, TIMEOUT=255.
module tb_tp_load_ctrl;
    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned WORDS     = 2;
    localparam int unsigned TIMEOUT   = 255;
    localparam int          BYTE_CLKS = 16 * CLK_DIV;
    localparam int          PER_CLKS  = 2 * CLK_DIV;
    localparam int          GAP       = BYTE_CLKS + 40;

    logic       clk = 1'b0;
    logic       rst_n, start, byte_valid, done_in;
    logic [1:0] mode_in;
    logic [7:0] byte_data;
    logic       byte_ready, sclk_out, mosi_out, busy, frame_done, err;
    logic [1:0] mode_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    tp_load_ctrl #(.CLK_DIV(CLK_DIV), .WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode_in    (mode_in),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .sclk_out   (sclk_out),
        .mosi_out   (mosi_out),
        .mode_out   (mode_out),
        .done_in    (done_in),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs start + WORDS byte handshakes, returns on the fall edge that enters WAIT_DONE.
    task automatic run_frame(input logic [1:0] mode, input logic [7:0] b0,
                             input logic [7:0] b1, input int gap);
        logic [7:0]  bytes [2];
        logic [15:0] cap = '0;
        logic        prev, hs;
        int rises = 0, sent = 0, hs_cyc = -100, gap_left = 0;
        int lat_ok = 0, first_bad = 0, stall_hi = 0, mode_bad = 0, ready_bad = 0;
        bytes[0] = b0;
        bytes[1] = b1;
        byte_data = b0;
        start = 1'b1;
        mode_in = mode;
        tick;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_mode", mode_out, mode);
        chk("start_ready", byte_ready, 1);
        chk("start_err", err, 0);
        byte_valid = 1'b1;
        prev = sclk_out;
        for (int i = 0; i < 1000 && !(rises == 16 && !sclk_out); i++) begin
            hs = byte_valid && byte_ready;
            tick;
            if (mode_out !== mode) mode_bad++;
            if (hs) begin
                sent++;
                hs_cyc = cyc;
                if (sclk_out !== 1'b0 || mosi_out !== bytes[sent-1][7]) first_bad++;
                if (sent == WORDS) byte_valid = 1'b0;
                else if (gap > 0) begin
                    byte_valid = 1'b0;
                    gap_left = gap;
                end else byte_data = bytes[sent];
            end else if (gap_left > 0) begin
                gap_left--;
                if (gap_left <= gap - BYTE_CLKS && sclk_out !== 1'b0) stall_hi++;
                if (gap_left == 0) begin
                    byte_valid = 1'b1;
                    byte_data = bytes[sent];
                end
            end
            if (sent == WORDS && byte_ready !== 1'b0) ready_bad++;
            if (sclk_out && !prev) begin
                cap = {cap[14:0], mosi_out};
                rises++;
                if (cyc - hs_cyc == CLK_DIV) lat_ok++;
            end
            prev = sclk_out;
        end
        chk("frame_end", (rises == 16 && !sclk_out), 1);
        chk("frame_bits", cap, {b0, b1});
        chk("frame_mode", mode_bad, 0);
        chk("frame_first_bit", first_bad, 0);
        chk("frame_rise_lat", lat_ok, WORDS);
        chk("frame_ready_drop", ready_bad, 0);
        chk("frame_stall_low", stall_hi, 0);
        chk("frame_sent", sent, WORDS);
        chk("wait_mosi", mosi_out, 0);
        chk("wait_busy", busy, 1);
    endtask

    initial begin
        int last_t, nt, int_bad, idle_bad, fd_cnt, fd_first, early, wait_bad;
        logic prev;

        rst_n = 1'b0; start = 1'b0; mode_in = 2'b00;
        byte_valid = 1'b0; byte_data = 8'h00; done_in = 1'b0;
        repeat (3) tick;
        chk("rst_sclk", sclk_out, 0);
        chk("rst_mosi", mosi_out, 0);
        chk("rst_mode", mode_out, 0);
        chk("rst_ready", byte_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_err", err, 0);

        // Idle: sclk free-runs; a held byte_valid must not be taken.
        rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'h5A;
        last_t = -1; nt = 0; int_bad = 0; idle_bad = 0;
        prev = sclk_out;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (sclk_out !== prev) begin
                if (last_t >= 0 && k - last_t != CLK_DIV) int_bad++;
                last_t = k;
                nt++;
            end
            if (mode_out !== 2'b00 || busy !== 1'b0 || err !== 1'b0 || byte_ready !== 1'b0) idle_bad++;
            prev = sclk_out;
        end
        chk("idle_period", int_bad, 0);
        chk("idle_toggles", (nt >= 4), 1);
        chk("idle_outputs", idle_bad, 0);

        // Frame A: back-to-back bytes, done_in raised in the 5th WAIT_DONE period.
        run_frame(2'b01, 8'hA5, 8'h3C, 0);
        wait_bad = 0;
        repeat (4 * PER_CLKS) begin
            tick;
            if (frame_done !== 1'b0 || mosi_out !== 1'b0 || busy !== 1'b1 || mode_out !== 2'b01) wait_bad++;
        end
        chk("wait_outputs", wait_bad, 0);
        done_in = 1'b1;
        fd_cnt = 0; fd_first = -1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = k;
            end
        end
        chk("fdone_pulses", fd_cnt, 1);
        chk("fdone_latency", (fd_first >= 2 && fd_first <= 3), 1);
        chk("done_mode", mode_out, 0);
        chk("done_busy", busy, 0);
        chk("done_err", err, 0);
        done_in = 1'b0;

        // Frame B: stall between bytes, then no done_in -> timeout.
        run_frame(2'b10, 8'hA5, 8'h3C, GAP);
        early = 0;
        for (int k = 1; k < int'(TIMEOUT) * PER_CLKS; k++) begin
            tick;
            if (err !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) early++;
        end
        chk("to_early", early, 0);
        tick;
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_mode", mode_out, 0);
        chk("to_fdone", frame_done, 0);

        // Frame C: valid start clears err; reset while sclk is high mid-byte.
        start = 1'b1;
        mode_in = 2'b01;
        tick;
        start = 1'b0;
        chk("restart_err", err, 0);
        chk("restart_busy", busy, 1);
        byte_valid = 1'b1;
        byte_data = 8'hFF;
        tick;
        byte_valid = 1'b0;
        repeat (CLK_DIV + 1) tick;
        chk("mid_sclk", sclk_out, 1);
        chk("mid_mosi", mosi_out, 1);
        rst_n = 1'b0;
        tick;
        chk("abort_sclk", sclk_out, 0);
        chk("abort_mosi", mosi_out, 0);
        chk("abort_mode", mode_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", byte_ready, 0);
        rst_n = 1'b1;
        tick;

        // Reserved mode flags err without leaving IDLE; RUN mode is a no-op.
        start = 1'b1;
        mode_in = 2'b11;
        tick;
        start = 1'b0;
        chk("rsvd_err", err, 1);
        chk("rsvd_busy", busy, 0);
        chk("rsvd_mode", mode_out, 0);
        start = 1'b1;
        mode_in = 2'b00;
        tick;
        start = 1'b0;
        tick;
        chk("run_busy", busy, 0);
        chk("run_mode", mode_out, 0);
        chk("run_ready", byte_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
